// File: rtl/seq_alu_pkg.sv
// rtl/seq_alu_pkg.sv - ALU control codes and FSM state encoding shared with the ALU control decoder.
package seq_alu_pkg;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_MUL = 3'b011;
  localparam logic [2:0] ALU_SUB = 3'b110;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_MUL  = 2'b01,
    S_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/seq_alu_mul.sv
// rtl/seq_alu_mul.sv - iterative shift-add multiplier datapath, one partial product per step.
// AW is WIDTH, or 2*WIDTH when the top needs the upper product half for overflow.
module seq_alu_mul #(
  parameter int WIDTH = 32,
  parameter int AW    = WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             step_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [AW-1:0]    prod_o
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic [AW-1:0]    acc_q, acc_d, acc_step;
  logic [AW-1:0]    mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  assign acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
  // The final step's sum is handed out directly so the top can register it on the same edge.
  assign prod_o   = acc_step;
  assign done_o   = step_i && (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    if (load_i) begin
      acc_d    = '0;
      mcand_d  = AW'(a_i);
      mplier_d = b_i;
      cnt_d    = '0;
    end else if (step_i) begin
      acc_d    = acc_step;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - execute-stage ALU: single-cycle add/sub/and/or, iterative mul, start/ready/valid.
// Optional SEQ_ALU_OVF_EN adds ovf_o and widens the multiplier accumulator to 2*WIDTH.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [2:0]       ALUCtrl_i,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  output logic             ready_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
`ifdef SEQ_ALU_OVF_EN
  output logic             ovf_o,
`endif
  output logic             zero_o
);

`ifdef SEQ_ALU_OVF_EN
  localparam int AW = 2 * WIDTH;
`else
  localparam int AW = WIDTH;
`endif

  state_t           state_q, state_d;
  logic             live_q;
  logic [WIDTH-1:0] data_q, data_d, alu_res;
  logic             zero_q;
  logic             accept, is_mul, mul_done;
  logic [AW-1:0]    mul_prod;

  // live_q keeps ready_o low until the first edge after reset release.
  assign ready_o = live_q && (state_q != S_MUL);
  assign valid_o = (state_q == S_DONE);
  assign data_o  = data_q;
  assign zero_o  = zero_q;
  assign accept  = start_i && ready_o;
  assign is_mul  = (ALUCtrl_i == ALU_MUL);

  always_comb begin
    alu_res = '0;
    case (ALUCtrl_i)
      ALU_AND: alu_res = data1_i & data2_i;
      ALU_OR:  alu_res = data1_i | data2_i;
      ALU_ADD: alu_res = data1_i + data2_i;
      ALU_SUB: alu_res = data1_i - data2_i;
      default: alu_res = '0;
    endcase
  end

`ifdef SEQ_ALU_OVF_EN
  logic alu_ovf, ovf_q, ovf_d;

  always_comb begin
    alu_ovf = 1'b0;
    case (ALUCtrl_i)
      ALU_ADD: alu_ovf = (data1_i[WIDTH-1] == data2_i[WIDTH-1]) && (alu_res[WIDTH-1] != data1_i[WIDTH-1]);
      ALU_SUB: alu_ovf = (data1_i[WIDTH-1] != data2_i[WIDTH-1]) && (alu_res[WIDTH-1] != data1_i[WIDTH-1]);
      default: alu_ovf = 1'b0;
    endcase
  end

  assign ovf_o = ovf_q;
`endif

  seq_alu_mul #(
    .WIDTH (WIDTH),
    .AW    (AW)
  ) u_mul (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .load_i (accept && is_mul),
    .step_i (state_q == S_MUL),
    .a_i    (data1_i),
    .b_i    (data2_i),
    .done_o (mul_done),
    .prod_o (mul_prod)
  );

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
`ifdef SEQ_ALU_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (accept) begin
          if (is_mul) begin
            state_d = S_MUL;
          end else begin
            state_d = S_DONE;
            data_d  = alu_res;
`ifdef SEQ_ALU_OVF_EN
            ovf_d   = alu_ovf;
`endif
          end
        end
      end
      S_MUL: begin
        if (mul_done) begin
          state_d = S_DONE;
          data_d  = mul_prod[WIDTH-1:0];
`ifdef SEQ_ALU_OVF_EN
          ovf_d   = |mul_prod[AW-1:WIDTH];
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
      live_q  <= 1'b0;
      data_q  <= '0;
      zero_q  <= 1'b1;
`ifdef SEQ_ALU_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      live_q  <= 1'b1;
      data_q  <= data_d;
      zero_q  <= (data_d == '0);
`ifdef SEQ_ALU_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Execute-stage ALU that consumes the 3-bit ALUCtrl code produced by the ALU control decoder.
- Add, sub, and, or complete in one cycle.
- mul runs as an iterative shift-add over WIDTH cycles.
- A start/ready/valid handshake lets the pipeline controller stall EX while a multiply is in flight.

Parameters:
- WIDTH, 32, operand and result width in bits; must be even and ≥ 4.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_i  input  1  asynchronous, active-low reset.
- start_i  input  1  request; accepted on a rising edge when ready_o=1.
- ALUCtrl_i  input  3  operation code, sampled at accept.
- data1_i  input  WIDTH  operand A, sampled at accept.
- data2_i  input  WIDTH  operand B, sampled at accept.
- ready_o  output  1  block can accept a request this cycle.
- valid_o  output  1  one-cycle pulse; data_o/zero_o are new this cycle.
- data_o  output  WIDTH  result; held until the next valid_o.
- zero_o  output  1  data_o == 0; held with data_o.

Behaviour:
- Reset is asynchronous and active-low.
  - While rst_i=0: state=IDLE, ready_o=0, valid_o=0, data_o=0, zero_o=1, iteration counter=0, operand/accumulator registers=0.
  - First rising edge after rst_i rises: ready_o=1.
- Op codes:
  - 010 add: A+B, mod 2^WIDTH.
  - 110 sub: A-B, mod 2^WIDTH.
  - 000 and, 001 or.
  - 011 mul: low WIDTH bits of A*B; equal for signed and unsigned operands.
  - Any other code: result 0, completes as a single-cycle op.
- States: IDLE, MUL, DONE.
- ready_o=1 in IDLE and DONE; ready_o=0 in MUL.
- Accept = start_i & ready_o at a rising edge; latches opcode and both operands.
- Single-cycle op accepted at edge k:
  - Result registered at edge k.
  - State DONE and valid_o=1 during cycle k+1.
- mul accepted at edge k:
  - Enters MUL with counter=0, acc=0, multiplicand=A, multiplier=B.
  - Each MUL cycle: if multiplier[0], acc += multiplicand; multiplicand <<= 1; multiplier >>= 1; counter++.
  - After WIDTH iterations (edge k+WIDTH): acc is loaded into data_o.
  - DONE during cycle k+WIDTH+1; total latency WIDTH+1 cycles.
- DONE:
  - valid_o=1 for exactly one cycle.
  - Next state is IDLE, or a new op if start_i is accepted in the same cycle (back-to-back, no bubble).
- start_i while ready_o=0: ignored, not queued; operand changes do not affect the op in flight.
- data_o and zero_o change only on the edge that produces a valid_o.
- Reset asserted mid-MUL: op aborted, no valid_o, all state to reset values.
- Counter width is clog2(WIDTH)+1; no wrap within an op.

Optional Feature:
- Macro: SEQ_ALU_OVF_EN.
- Defined:
  - Extra output ovf_o (1 bit), reset 0, updated with valid_o.
  - ovf_o=1 on signed two's-complement overflow of add or sub.
  - For mul, ovf_o=1 if the full 2*WIDTH unsigned product is nonzero above bit WIDTH-1; the accumulator widens to 2*WIDTH.
  - ovf_o=0 for all other codes.
- Undefined: no ovf_o port, WIDTH-bit accumulator, all other behaviour identical.

Decomposition:
- Package seq_alu_pkg:
  - localparam codes ALU_AND=3'b000, ALU_OR=3'b001, ALU_ADD=3'b010, ALU_MUL=3'b011, ALU_SUB=3'b110.
  - State encoding IDLE/MUL/DONE.
  - Shared with the ALU control decoder so both ends agree on the codes.
- Sub-module seq_alu_mul: iterative shift-add datapath (acc, multiplicand, multiplier, counter) with a load strobe and a done flag. The seq_alu FSM sequences it.

Test Plan:
- Reset held 3 cycles, then released: ready_o=0 during reset, data_o=0, zero_o=1; ready_o=1 after the first edge.
- add 0x7FFFFFFF+1: valid_o one cycle after accept, data_o=0x80000000, zero_o=0; ovf_o=1 if SEQ_ALU_OVF_EN is defined.
- sub 5-5, then and 0xF0F0&0x0FF0 back-to-back (second start issued in the DONE cycle): data_o=0 with zero_o=1, then 0x00F0; two valid_o pulses one cycle apart.
- mul 0xFFFFFFFF*3 (WIDTH=32): ready_o=0 for 32 cycles, valid_o at accept+33, data_o=0xFFFFFFFD.
- During that mul, drive start_i=1 with add 1+1: ignored; no extra valid_o; mul result unchanged.
- Unknown code 3'b111: valid_o after 1 cycle, data_o=0, zero_o=1.
- rst_i pulsed low at MUL iteration 10: no valid_o; data_o=0; ready_o returns after reset release.
